fetch_align_queue: RTL and testbench

Parametrised second fetch stage. Buffers cache blocks in a circular byte queue and aligns up to LANES variable-length instructions per cycle, replacing the fixed two-instruction aligner. It sits between the block-fetch stage (cache read) and decode, and reports bytes consumed per cycle so the PC can advance. It supports redirects (flush plus entry byte offset) and back-pressure in both directions.

---
 rtl/fetch_align_queue_if.sv | 46 ++++
 rtl/fetch_align_queue.sv | 181 ++++++++++++++++++
 tb/tb_fetch_align_queue.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_align_queue_if
// Handshake/bus bundle between the block-fetch stage, fetch_align_queue and
// decode.
//   flush_i           redirect: discard queued bytes
//   block_valid_i     a cache block is offered
//   block_i           block data, byte k at [8k+7:8k]
//   block_offset_i    first valid byte inside block_i
//   block_ready_o     queue can take a full block this cycle
//   out_ready_i       decode accepts every valid lane this cycle
//   instr_o           LANES aligned instructions, zero-filled above length
//   format_o          per lane: 0 = short, 1 = long
//   valid_o           per-lane valid, always a contiguous prefix
//   consumed_bytes_o  bytes retired this cycle (0 when nothing pops)
// slave is the queue side; master is the fetch/decode side.
// -----------------------------------------------------------------------------
interface fetch_align_queue_if #(
   parameter int BLOCK_BYTES = 32,
   parameter int LANES       = 2,
   parameter int LONG_BYTES  = 8,
   parameter int INSTR_W     = 64
);
   localparam int OFF_W = $clog2(BLOCK_BYTES);
   localparam int CB_W  = $clog2(LANES*LONG_BYTES+1);

   logic                     flush_i;
   logic                     block_valid_i;
   logic [BLOCK_BYTES*8-1:0] block_i;
   logic [OFF_W-1:0]         block_offset_i;
   logic                     block_ready_o;
   logic                     out_ready_i;
   logic [LANES*INSTR_W-1:0] instr_o;
   logic [LANES-1:0]         format_o;
   logic [LANES-1:0]         valid_o;
   logic [CB_W-1:0]          consumed_bytes_o;

   modport master (
      output flush_i, block_valid_i, block_i, block_offset_i, out_ready_i,
      input  block_ready_o, instr_o, format_o, valid_o, consumed_bytes_o
   );

   modport slave (
      input  flush_i, block_valid_i, block_i, block_offset_i, out_ready_i,
      output block_ready_o, instr_o, format_o, valid_o, consumed_bytes_o
   );
endinterface

// File: rtl/fetch_align_queue.sv
// -----------------------------------------------------------------------------
// fetch_align_queue
// Second fetch stage: cache blocks are appended to a circular byte queue and
// up to LANES variable-length instructions are aligned from its head each
// cycle. Instruction format is bit 7 of the first byte (0 = SHORT_BYTES long,
// 1 = LONG_BYTES long).
// Ports:
//   clock_i        rising-edge clock
//   reset_i        asynchronous, active-low reset
//   bus_io         fetch_align_queue_if.slave (block input, lane output)
//   stat_instr_o   instructions popped, wraps at 2^32   (FETCH_ALIGN_STATS_EN)
//   stat_starve_o  cycles decode was ready but lane 0 was empty
//                                                     (FETCH_ALIGN_STATS_EN)
// Optional feature: define FETCH_ALIGN_STATS_EN to add the two counters.
// -----------------------------------------------------------------------------
module fetch_align_queue #(
   parameter int BLOCK_BYTES  = 32,
   parameter int QUEUE_BLOCKS = 2,
   parameter int LANES        = 2,
   parameter int SHORT_BYTES  = 4,
   parameter int LONG_BYTES   = 8,
   parameter int INSTR_W      = 64
) (
   input  logic               clock_i,
   input  logic               reset_i,
   fetch_align_queue_if.slave bus_io
`ifdef FETCH_ALIGN_STATS_EN
   ,
   output logic [31:0]        stat_instr_o,
   output logic [31:0]        stat_starve_o
`endif
);
   localparam int QUEUE_BYTES = BLOCK_BYTES*QUEUE_BLOCKS;
   localparam int PTR_W       = $clog2(QUEUE_BYTES);
   localparam int CNT_W       = PTR_W + 1;
   localparam int CB_W        = $clog2(LANES*LONG_BYTES+1);

   logic [PTR_W-1:0]         head_q, head_d;
   logic [PTR_W-1:0]         tail_q, tail_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [7:0]               mem_q [QUEUE_BYTES];

   logic                     push, pop;
   logic [CNT_W-1:0]         push_bytes;
   logic [CB_W-1:0]          lane_bytes;
   logic [LANES-1:0]         lane_valid, lane_fmt;
   logic [LANES*INSTR_W-1:0] lane_instr;
   logic [PTR_W-1:0]         wr_addr [BLOCK_BYTES];

   // Room for a whole block is judged on the registered count only, so a pop
   // in the same cycle never lets a block in early.
   assign bus_io.block_ready_o = reset_i && !bus_io.flush_i &&
                                 (count_q <= CNT_W'(QUEUE_BYTES - BLOCK_BYTES));

   assign push       = bus_io.block_valid_i && bus_io.block_ready_o;
   assign push_bytes = CNT_W'(BLOCK_BYTES) - CNT_W'(bus_io.block_offset_i);

   // Lane k starts where lane k-1 ended; a lane is valid only if every lane
   // before it is valid and all its bytes are already in the queue. Invalid
   // lanes are driven to zero, which also keeps the outputs quiet in reset.
   // NOTE: every variable written here gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      logic [PTR_W-1:0] start;
      logic [7:0]       first;
      logic             lane_ok;
      int               cum;
      int               len;
      start      = head_q;
      first      = '0;
      lane_ok    = 1'b1;
      cum        = 0;
      len        = 0;
      lane_valid = '0;
      lane_fmt   = '0;
      lane_instr = '0;
      for (int k = 0; k < LANES; k++) begin
         first   = mem_q[start];
         len     = first[7] ? LONG_BYTES : SHORT_BYTES;
         lane_ok = lane_ok && !bus_io.flush_i && ((cum + len) <= int'(count_q));
         if (lane_ok) begin
            lane_valid[k] = 1'b1;
            lane_fmt[k]   = first[7];
            // Byte addresses wrap modulo the queue, so an instruction split
            // across the end of storage is reassembled in order.
            for (int b = 0; b < LONG_BYTES; b++) begin
               if (b < len) begin
                  lane_instr[k*INSTR_W + 8*b +: 8] = mem_q[start + PTR_W'(b)];
               end
            end
            cum = cum + len;
         end
         start = start + PTR_W'(len);
      end
      lane_bytes = CB_W'(cum);
   end

   assign pop                     = bus_io.out_ready_i && lane_valid[0];
   assign bus_io.valid_o          = lane_valid;
   assign bus_io.format_o         = lane_fmt;
   assign bus_io.instr_o          = lane_instr;
   assign bus_io.consumed_bytes_o = pop ? lane_bytes : '0;

   // Byte i of the block lands at tail + (i - offset); bytes below the offset
   // are skipped.
   always_comb begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         wr_addr[i] = tail_q + PTR_W'(i) - PTR_W'(bus_io.block_offset_i);
      end
   end

   // NOTE: the byte storage has no reset; head/tail/count decide which bytes
   // are live, so stale contents are never observed and the array can map to
   // plain flops or RAM without a clear path.
   always_ff @(posedge clock_i) begin
      if (push) begin
         for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i >= int'(bus_io.block_offset_i)) begin
               mem_q[wr_addr[i]] <= bus_io.block_i[8*i +: 8];
            end
         end
      end
   end

   // Flush wins over any push or pop in the same cycle.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus_io.flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (pop) begin
            head_d = head_q + PTR_W'(lane_bytes);
         end
         if (push) begin
            tail_d = tail_q + PTR_W'(push_bytes);
         end
         count_d = count_q + (push ? push_bytes : '0) - (pop ? CNT_W'(lane_bytes) : '0);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

`ifdef FETCH_ALIGN_STATS_EN
   // Counters survive a flush; only reset clears them.
   logic [31:0] stat_instr_q, stat_starve_q;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         stat_instr_q  <= '0;
         stat_starve_q <= '0;
      end else begin
         if (pop) begin
            stat_instr_q <= stat_instr_q + 32'($countones(lane_valid));
         end
         if (bus_io.out_ready_i && !lane_valid[0]) begin
            stat_starve_q <= stat_starve_q + 32'd1;
         end
      end
   end

   assign stat_instr_o  = stat_instr_q;
   assign stat_starve_o = stat_starve_q;
`endif

endmodule

// File: tb/tb_fetch_align_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_align_queue
// Directed bench for fetch_align_queue. A byte-queue model predicts every
// output on each falling edge; literal expectations pin key cycles.
// Define FETCH_ALIGN_STATS_EN to include the statistics counters.
// -----------------------------------------------------------------------------
module tb_fetch_align_queue;
   localparam int BLOCK_BYTES  = 32;
   localparam int QUEUE_BLOCKS = 2;
   localparam int LANES        = 2;
   localparam int SHORT_BYTES  = 4;
   localparam int LONG_BYTES   = 8;
   localparam int INSTR_W      = 64;
   localparam int QUEUE_BYTES  = BLOCK_BYTES*QUEUE_BLOCKS;

   logic clk;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;

   fetch_align_queue_if #(
      .BLOCK_BYTES(BLOCK_BYTES), .LANES(LANES),
      .LONG_BYTES(LONG_BYTES), .INSTR_W(INSTR_W)
   ) bus ();

`ifdef FETCH_ALIGN_STATS_EN
   logic [31:0] stat_instr, stat_starve;
   int unsigned m_instr_cnt = 0;
   int unsigned m_starve    = 0;
`endif

   fetch_align_queue #(
      .BLOCK_BYTES(BLOCK_BYTES), .QUEUE_BLOCKS(QUEUE_BLOCKS), .LANES(LANES),
      .SHORT_BYTES(SHORT_BYTES), .LONG_BYTES(LONG_BYTES), .INSTR_W(INSTR_W)
   ) dut (
      .clock_i (clk),
      .reset_i (reset_n),
      .bus_io  (bus)
`ifdef FETCH_ALIGN_STATS_EN
      ,
      .stat_instr_o  (stat_instr),
      .stat_starve_o (stat_starve)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Block with byte k = base + k; instruction start bytes get bit 7 from
   // fmts (bit i = format of instruction i counted from block byte 0).
   function automatic logic [255:0] mk_block(input logic [7:0] base, input logic [7:0] fmts);
      logic [255:0] blk;
      int pos;
      int i;
      for (int k = 0; k < BLOCK_BYTES; k++) blk[8*k +: 8] = base + 8'(k);
      pos = 0;
      i   = 0;
      while (pos < BLOCK_BYTES) begin
         blk[8*pos + 7] = fmts[i];
         pos = pos + (fmts[i] ? LONG_BYTES : SHORT_BYTES);
         i++;
      end
      return blk;
   endfunction

   // ---------------- reference model: plain byte queue ----------------
   logic [7:0] mq[$];

   always @(negedge clk) begin : compare
      logic [LANES*INSTR_W-1:0] e_instr;
      logic [LANES-1:0]         e_valid, e_fmt;
      logic                     e_ready, prev_ok;
      int                       pos, len, e_cons, nvalid;
      if (!reset_n) begin
         mq.delete();
         check("rst_valid", bus.valid_o, 0);
         check("rst_format", bus.format_o, 0);
         check("rst_instr", bus.instr_o, 0);
         check("rst_consumed", bus.consumed_bytes_o, 0);
         check("rst_ready", bus.block_ready_o, 0);
`ifdef FETCH_ALIGN_STATS_EN
         m_instr_cnt = 0;
         m_starve    = 0;
         check("rst_stat_instr", stat_instr, 0);
         check("rst_stat_starve", stat_starve, 0);
`endif
      end else begin
         e_instr = '0;
         e_valid = '0;
         e_fmt   = '0;
         pos     = 0;
         nvalid  = 0;
         prev_ok = 1'b1;
         for (int k = 0; k < LANES; k++) begin
            if (prev_ok && !bus.flush_i && pos < mq.size()) begin
               len = mq[pos][7] ? LONG_BYTES : SHORT_BYTES;
               if (pos + len <= mq.size()) begin
                  e_valid[k] = 1'b1;
                  e_fmt[k]   = mq[pos][7];
                  for (int b = 0; b < len; b++) e_instr[k*INSTR_W + 8*b +: 8] = mq[pos+b];
                  pos = pos + len;
                  nvalid++;
               end else prev_ok = 1'b0;
            end else prev_ok = 1'b0;
         end
         e_cons  = (bus.out_ready_i && e_valid[0]) ? pos : 0;
         e_ready = ((QUEUE_BYTES - mq.size()) >= BLOCK_BYTES) && !bus.flush_i;

         check("m_valid", bus.valid_o, e_valid);
         check("m_consumed", bus.consumed_bytes_o, e_cons);
         check("m_ready", bus.block_ready_o, e_ready);
         for (int k = 0; k < LANES; k++) begin
            if (e_valid[k]) begin
               check($sformatf("m_fmt%0d", k), bus.format_o[k], e_fmt[k]);
               check($sformatf("m_instr%0d", k), bus.instr_o[k*INSTR_W +: INSTR_W],
                     e_instr[k*INSTR_W +: INSTR_W]);
            end
         end
`ifdef FETCH_ALIGN_STATS_EN
         check("m_stat_instr", stat_instr, m_instr_cnt);
         check("m_stat_starve", stat_starve, m_starve);
         if (e_cons != 0) m_instr_cnt = m_instr_cnt + nvalid;
         if (bus.out_ready_i && !e_valid[0]) m_starve = m_starve + 1;
`endif
         // State the DUT must hold after the coming rising edge.
         if (bus.flush_i) mq.delete();
         else begin
            repeat (e_cons) void'(mq.pop_front());
            if (bus.block_valid_i && e_ready) begin
               for (int i = int'(bus.block_offset_i); i < BLOCK_BYTES; i++)
                  mq.push_back(bus.block_i[8*i +: 8]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_blk(input logic [255:0] data, input int off);
      bus.block_valid_i  = 1'b1;
      bus.block_i        = data;
      bus.block_offset_i = 5'(off);
      tick();
      bus.block_valid_i  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      reset_n            = 1'b0;
      bus.flush_i        = 1'b0;
      bus.block_valid_i  = 1'b0;
      bus.block_i        = '0;
      bus.block_offset_i = '0;
      bus.out_ready_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("init_ready_in_reset", bus.block_ready_o, 0);
      reset_n = 1'b1;
      #1;
      check("init_ready", bus.block_ready_o, 1);
      check("init_valid", bus.valid_o, 0);

      // 1: eight short instructions, four 8-byte pops.
      bus.out_ready_i = 1'b1;
      push_blk(mk_block(8'h00, 8'h00), 0);
      check("t1_valid", bus.valid_o, 2'b11);
      check("t1_consumed", bus.consumed_bytes_o, 8);
      check("t1_lane0", bus.instr_o[63:0], 64'h0000_0000_0302_0100);
      check("t1_lane1", bus.instr_o[127:64], 64'h0000_0000_0706_0504);
      check("t1_ready", bus.block_ready_o, 1);
      repeat (3) tick();
      check("t1_valid_last", bus.valid_o, 2'b11);
      tick();
      check("t1_empty", bus.valid_o, 0);

      // 2: four long instructions, then short,long,short pattern.
      push_blk(mk_block(8'h40, 8'hFF), 0);
      check("t2_format", bus.format_o, 2'b11);
      check("t2_consumed", bus.consumed_bytes_o, 16);
      check("t2_lane0", bus.instr_o[63:0], 64'h4746_4544_4342_41C0);
      tick();
      check("t2_valid2", bus.valid_o, 2'b11);
      tick();
      check("t2_empty", bus.valid_o, 0);
      push_blk(mk_block(8'h00, 8'b0001_0010), 0);
      check("t2_sls_format", bus.format_o, 2'b10);
      check("t2_sls_consumed", bus.consumed_bytes_o, 12);
      check("t2_sls_lane1", bus.instr_o[127:64], 64'h0B0A_0908_0706_0584);
      repeat (3) tick();
      check("t2_sls_empty", bus.valid_o, 0);

      // Filler of 24 bytes moves head/tail to byte 56.
      push_blk(mk_block(8'h30, 8'h00), 8);
      repeat (3) tick();
      check("fill_empty", bus.valid_o, 0);

      // 3: short at 56..59, then a long at 60..63,0..3 across the wrap.
      push_blk(mk_block(8'h50, 8'h00), 28);
      check("t3_valid_short", bus.valid_o, 2'b01);
      check("t3_consumed4", bus.consumed_bytes_o, 4);
      push_blk(mk_block(8'h10, 8'hFF), 0);
      check("t3_wrap_lane0", bus.instr_o[63:0], 64'h1716_1514_1312_1190);
      check("t3_wrap_lane1", bus.instr_o[127:64], 64'h1F1E_1D1C_1B1A_1998);
      check("t3_consumed16", bus.consumed_bytes_o, 16);
      repeat (2) tick();
      check("t3_empty", bus.valid_o, 0);

      // 4: fill queue with decode stalled, hold a third block.
      bus.out_ready_i = 1'b0;
      push_blk(mk_block(8'h00, 8'h00), 0);
      push_blk(mk_block(8'h20, 8'h00), 0);
      check("t4_full_ready", bus.block_ready_o, 0);
      check("t4_full_valid", bus.valid_o, 2'b11);
      check("t4_stall_consumed", bus.consumed_bytes_o, 0);
      bus.block_valid_i  = 1'b1;
      bus.block_i        = mk_block(8'h60, 8'h00);
      bus.block_offset_i = '0;
      repeat (2) tick();
      check("t4_held_ready", bus.block_ready_o, 0);
      bus.out_ready_i = 1'b1;
      n = 0;
      while (!bus.block_ready_o && n < 10) begin
         tick();
         n++;
      end
      check("t4_ready_after_pops", n, 4);
      tick();
      bus.block_valid_i = 1'b0;
      repeat (7) tick();
      check("t4_empty", bus.valid_o, 0);

      // 5: flush with 20 bytes queued, competing push and pop.
      bus.out_ready_i = 1'b0;
      push_blk(mk_block(8'h70, 8'h00), 12);
      check("t5_pre_valid", bus.valid_o, 2'b11);
      bus.flush_i        = 1'b1;
      bus.block_valid_i  = 1'b1;
      bus.block_i        = mk_block(8'h00, 8'h00);
      bus.block_offset_i = '0;
      bus.out_ready_i    = 1'b1;
      #1;
      check("t5_flush_valid", bus.valid_o, 0);
      check("t5_flush_consumed", bus.consumed_bytes_o, 0);
      check("t5_flush_ready", bus.block_ready_o, 0);
      tick();
      bus.flush_i       = 1'b0;
      bus.block_valid_i = 1'b0;
      #1;
      check("t5_post_valid", bus.valid_o, 0);
      check("t5_post_ready", bus.block_ready_o, 1);
      bus.out_ready_i = 1'b0;
      push_blk(mk_block(8'h20, 8'h00), 8);
      check("t5_offset_lane0", bus.instr_o[63:0], 64'h0000_0000_2B2A_2928);
      bus.out_ready_i = 1'b1;
      repeat (3) tick();
      check("t5_empty", bus.valid_o, 0);

      // 6: asynchronous reset between edges.
      bus.out_ready_i = 1'b0;
      push_blk(mk_block(8'h05, 8'h00), 0);
      check("t6_pre_valid", bus.valid_o, 2'b11);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_async_valid", bus.valid_o, 0);
      check("t6_async_ready", bus.block_ready_o, 0);
      check("t6_async_consumed", bus.consumed_bytes_o, 0);
`ifdef FETCH_ALIGN_STATS_EN
      check("t6_stat_instr", stat_instr, 0);
`endif
      repeat (2) tick();
      reset_n = 1'b1;
      #1;
      check("t6_release_ready", bus.block_ready_o, 1);
      check("t6_release_valid", bus.valid_o, 0);
      bus.out_ready_i = 1'b1;
      repeat (2) tick();
      check("t6_no_stale", bus.valid_o, 0);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
